// File: rtl/sample_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : sample_unpacker
// Purpose  : Reads packed byte pairs from SRAM and streams them out as 16-bit
//            samples, high byte first. Optional level shift: UNPACKER_LEVEL_SHIFT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sample_unpacker #(
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 18'd0,
    parameter logic [ADDR_WIDTH-1:0] NUM_WORDS  = 18'd38400
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] SRAM_address,
    output logic                  SRAM_we_n,
    input  logic [15:0]           SRAM_read_data,
    output logic [15:0]           sample_out,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] issue_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   out_cnt_q;
    logic [1:0]            inflight_q;
    logic [15:0]           fifo_q [4];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [2:0]            count_q;
    logic                  half_q;
    logic [15:0]           sample_q;
    logic                  valid_q;

    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_xfer;
    logic                  w_last;
    logic [2:0]            w_credits;
    logic [7:0]            w_byte;
    logic [15:0]           w_sample;

    // Reads in flight plus buffered words never exceed the FIFO depth.
    assign w_credits = {2'b00, inflight_q[0]} + {2'b00, inflight_q[1]} + count_q;
    assign w_issue   = (state_q == S_FETCH) && (issue_cnt_q != NUM_WORDS) && (w_credits < 3'd4);
    assign w_push    = inflight_q[1];
    assign w_xfer    = valid_q && sample_ready;
    assign w_load    = (count_q != 3'd0) && (!valid_q || sample_ready);
    assign w_pop     = w_load && half_q;
    assign w_last    = w_xfer && (out_cnt_q == ({NUM_WORDS, 1'b0} - (ADDR_WIDTH+1)'(1)));
    assign w_byte    = half_q ? fifo_q[rd_ptr_q][7:0] : fifo_q[rd_ptr_q][15:8];

`ifdef UNPACKER_LEVEL_SHIFT_EN
    assign w_sample = {8'h00, w_byte} - 16'd128;
`else
    assign w_sample = {8'h00, w_byte};
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (issue_cnt_q == NUM_WORDS) state_d = S_DRAIN;
            S_DRAIN: if (w_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            addr_q      <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 2'b00;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            half_q      <= 1'b0;
            sample_q    <= 16'h0000;
            valid_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                ptr_q       <= BASE_ADDR;
                issue_cnt_q <= '0;
                out_cnt_q   <= '0;
            end else begin
                if (w_issue) begin
                    addr_q      <= ptr_q;
                    ptr_q       <= ptr_q + ADDR_WIDTH'(1);
                    issue_cnt_q <= issue_cnt_q + ADDR_WIDTH'(1);
                end
                if (w_xfer) out_cnt_q <= out_cnt_q + (ADDR_WIDTH+1)'(1);
            end
            inflight_q <= {inflight_q[0], w_issue};
            if (w_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, w_push} - {2'b00, w_pop};
            // The output stage refills on the same edge a sample is taken.
            if (w_load) begin
                sample_q <= w_sample;
                valid_q  <= 1'b1;
                half_q   <= ~half_q;
            end else if (w_xfer) begin
                valid_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= 16'h0000;
        end else if (w_push) begin
            fifo_q[wr_ptr_q] <= SRAM_read_data;
        end
    end

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/sample_unpacker.md
Name: sample_unpacker

Overview:
Reads packed 8-bit pixel pairs from external SRAM and emits one signed 16-bit sample per handshake. It is the read-side counterpart of the 16-to-8-bit saturating output stage: samples that were clipped and packed two per SRAM word are unpacked and level-shifted back into the signed 16-bit domain. It feeds the transform/upsampling datapath. It owns SRAM address generation, read latency, and a small prefetch buffer under downstream backpressure.

Parameters:
ADDR_WIDTH, 18, SRAM address width.
BASE_ADDR, 18'd0, first SRAM word address read.
NUM_WORDS, 18'd38400, words per run; each word holds 2 samples. Legal range is 1..2^ADDR_WIDTH-1.

Ports:
Clock  input  1  system clock; all logic is on the rising edge.
Resetn  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse that begins a run; honoured only in S_IDLE.
SRAM_address  output  ADDR_WIDTH  word address presented to the SRAM.
SRAM_we_n  output  1  write enable, active low; held at 1.
SRAM_read_data  input  16  read data, valid exactly 2 cycles after its address.
sample_out  output  16  signed sample.
sample_valid  output  1  sample_out is valid.
sample_ready  input  1  consumer accepts the sample; a transfer occurs when valid and ready are both high.
busy  output  1  high from the accepted start until done.
done  output  1  one-cycle pulse after the final sample transfer.

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, sample_out=0, sample_valid=0, busy=0, done=0. Reset also clears the FSM, FIFO, pointers, counters and the read-latency tracker.
- FSM states: S_IDLE, S_FETCH, S_DRAIN, S_DONE.
  - S_IDLE: on start, go to S_FETCH, set busy=1 and load the issue pointer with BASE_ADDR.
  - S_FETCH: issue reads. Go to S_DRAIN once NUM_WORDS addresses have been issued.
  - S_DRAIN: wait for the final sample transfer, then go to S_DONE.
  - S_DONE: done=1 for one cycle, busy=0, then return to S_IDLE.
- Read issue: a read is issued in a cycle when (in-flight reads + FIFO occupancy) < 4.
  - Issuing a read drives SRAM_address=pointer and increments the pointer.
  - In-flight reads are tracked with a 2-stage valid shift register.
  - SRAM_address holds its last value when no read is issued.
- Word FIFO: 4 entries of 16 bits, with occupancy counter and wrap-around pointers. The credit rule guarantees it never overflows. A simultaneous push and pop leaves the count unchanged.
- Unpack order: the high byte [15:8] is emitted first, then the low byte [7:0]. A half-select flag toggles on each transfer, and the FIFO pops on the transfer of the low byte.
- Arithmetic: sample = {8'h00, byte} - 16'd128, giving -128..127 two's complement in 16 bits. Examples: byte 0x00 gives 0xFF80; byte 0xFF gives 0x007F.
- Output register: sample_out and sample_valid are registered, giving 1 cycle from FIFO head to valid.
  - While valid is high and ready is low, sample_out and sample_valid hold stable.
  - A new sample may be presented in the cycle after a transfer, so back-to-back throughput is 1 sample/cycle.
- Latency: first sample_valid rises 4 cycles after the start pulse (issue, +2 SRAM, +1 FIFO/output register).
- Boundaries:
  - start while busy is ignored.
  - With NUM_WORDS=1, exactly 2 samples are produced.
  - done rises the cycle after the last transfer and does not depend on sample_ready afterwards.
  - Reset mid-run aborts immediately; in-flight SRAM returns are discarded and no done is produced.

Optional Feature:
Macro: UNPACKER_LEVEL_SHIFT_EN.
- Defined: subtract 128 as described above.
- Undefined: sample = {8'h00, byte}, zero-extended with no shift. All timing is identical in both builds.

Test Plan:
- Macro defined, BASE_ADDR=0, NUM_WORDS=2, SRAM[0]=16'h80FF, SRAM[1]=16'h0001, ready=1 -> samples 0x0000, 0x007F, 0xFF80, 0xFF81 on consecutive cycles; first valid 4 cycles after start; done 1 cycle after the 4th transfer.
- NUM_WORDS=16, ready held low for 20 cycles after start -> exactly addresses 0..3 issued, then SRAM_address stalls; the first sample is held stable throughout; after release, all 32 samples arrive in order with none lost or duplicated.
- Random ready toggling (50%), NUM_WORDS=100, SRAM[i]=i*257 -> the sample stream matches the reference model byte-for-byte; busy stays high until done.
- start pulsed again mid-run -> ignored: address sequence unbroken, a single done pulse.
- Resetn asserted during word 5 of a 10-word run -> all outputs return to reset values immediately; a new start re-reads from BASE_ADDR with no stale sample.
- Macro undefined, SRAM[0]=16'h80FF, NUM_WORDS=1 -> samples 0x0080, 0x00FF.
